sine_nco: RTL



---
 rtl/sine_nco.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/sine_nco.sv
// sine_nco -- numerically controlled oscillator with a quarter-wave sine table.
//
// A phase accumulator advances by the active tuning word on every sample_en
// strobe. The top ADDR_W phase bits address a quarter-wave table. Quadrant
// symmetry rebuilds the full-cycle sine. Square, saw and triangle waves come
// straight from the phase. Output samples are offset binary, DATA_W bits wide.
//
// Ports
//   clock      single clock, every register updates on posedge
//   reset      synchronous, active-high
//   sample_en  one-cycle strobe, requests one output sample (may be held high)
//   tw_in      tuning word (phase increment, unsigned, modulo 2^PHASE_W)
//   tw_load    capture tw_in as the pending tuning word
//   phase_clr  force the phase accumulator to 0
//   wave_sel   0 sine, 1 square, 2 saw, 3 triangle (sampled with sample_en)
//   amp        8-bit output gain, present only with SINE_NCO_AMP_EN
//   sine       registered output sample
//   out_valid  one-cycle pulse whenever sine updates
//
// Optional build macro SINE_NCO_AMP_EN adds the amp input and one scaling
// stage, so latency is 4 instead of 3.
//
// The quarter-wave table T[i] = round(M*sin(pi/2*i/Q)) is computed at
// elaboration. ROM_FILE names the equivalent hex table image and is kept
// for parameter compatibility with existing instantiations.
module sine_nco #(
   parameter int PHASE_W  = 24,
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 16,
   parameter     ROM_FILE = "sine_quarter.hex"
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              sample_en,
   input  logic [PHASE_W-1:0] tw_in,
   input  logic              tw_load,
   input  logic              phase_clr,
   input  logic [1:0]        wave_sel,
`ifdef SINE_NCO_AMP_EN
   input  logic [7:0]        amp,
`endif
   output logic [DATA_W-1:0] sine,
   output logic              out_valid
);

   localparam int Q    = 1 << (ADDR_W-2);
   localparam int K_W  = ADDR_W-2;
   localparam int I_W  = ADDR_W-1;
   // Phase bits carried into S1: enough for the table address and for the
   // DATA_W+1 bits the triangle wave needs.
   localparam int SL_W = (DATA_W+1 > ADDR_W) ? DATA_W+1 : ADDR_W;
`ifdef SINE_NCO_AMP_EN
   localparam int LAT  = 4;
`else
   localparam int LAT  = 3;
`endif
   localparam logic [DATA_W-1:0] M_D = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [I_W-1:0]    Q_I = {1'b1, {K_W{1'b0}}};

   if (PHASE_W < DATA_W+1 || PHASE_W < ADDR_W || ADDR_W < 3 || ROM_FILE == "") begin : g_bad_cfg
      $error("sine_nco: illegal parameter combination");
   end

   // Table image, built with a fixed-point (2^-56) Taylor series of sin.
   // The precision is far finer than one output LSB, so rounding matches
   // round(M*sin(x)).
   function automatic logic [(Q+1)*DATA_W-1:0] build_rom();
      logic [(Q+1)*DATA_W-1:0] img;
      logic signed [127:0] half_pi, x, term, acc, v, ii, qq, den, m_w, rnd;
      half_pi = 128'sd113187804032455044;
      m_w     = (128'sd1 <<< (DATA_W-1)) - 128'sd1;
      rnd     = 128'sd1 <<< 55;
      qq      = 128'(Q);
      img     = '0;
      for (int i = 0; i <= Q; i++) begin
         ii   = 128'(i);
         x    = (half_pi * ii) / qq;
         acc  = x;
         term = x;
         for (int n = 1; n <= 12; n++) begin
            den  = 128'(2*n*(2*n+1));
            term = (term * x) >>> 56;
            term = (term * x) >>> 56;
            term = -term / den;
            acc  = acc + term;
         end
         v = (acc * m_w + rnd) >>> 56;
         img[i*DATA_W +: DATA_W] = v[DATA_W-1:0];
      end
      return img;
   endfunction

   localparam logic [(Q+1)*DATA_W-1:0] ROM = build_rom();

   // state
   logic [PHASE_W-1:0] phase_q, phase_d;
   logic [PHASE_W-1:0] tw_active_q, tw_active_d;
   logic [PHASE_W-1:0] tw_pending_q, tw_pending_d;
   logic               pend_q, pend_d;
   logic [LAT-1:0]     vld_q, vld_d;
   logic [SL_W-1:0]    s1_phase_q, s1_phase_d;
   logic [1:0]         s1_wave_q, s1_wave_d;
   logic [DATA_W-1:0]  s2_rom_q, s2_rom_d;
   logic               s2_neg_q, s2_neg_d;
   logic               s2_is_sine_q, s2_is_sine_d;
   logic [DATA_W-1:0]  s2_alt_q, s2_alt_d;
   logic [DATA_W-1:0]  sine_q, sine_d;
`ifdef SINE_NCO_AMP_EN
   logic [7:0]         s1_amp_q, s1_amp_d;
   logic [7:0]         s2_amp_q, s2_amp_d;
   logic [7:0]         s3_amp_q, s3_amp_d;
   logic [DATA_W-1:0]  s3_raw_q, s3_raw_d;
   logic signed [DATA_W:0]   amp_dev;
   logic signed [DATA_W+9:0] amp_prod;
   logic signed [DATA_W+9:0] amp_sh;
`endif

   // combinational temporaries
   logic [PHASE_W-1:0] tw_eff;
   logic [PHASE_W-1:0] p_used;
   logic [ADDR_W-1:0]  s1_addr;
   logic [K_W-1:0]     s1_k;
   logic [I_W-1:0]     s1_idx;
   logic [DATA_W:0]    s1_u;
   logic [DATA_W-1:0]  raw;

   always_comb begin
      // A coincident tw_load bypasses the pending register for this increment.
      tw_eff = pend_q ? tw_pending_q : tw_active_q;
      if (tw_load) tw_eff = tw_in;
      p_used = phase_clr ? '0 : phase_q;

      phase_d      = phase_q;
      tw_active_d  = tw_active_q;
      tw_pending_d = tw_pending_q;
      pend_d       = pend_q;
      if (sample_en) begin
         phase_d     = p_used + tw_eff;
         tw_active_d = tw_eff;
         pend_d      = 1'b0;
      end else begin
         if (phase_clr) phase_d = '0;
         if (tw_load) begin
            tw_pending_d = tw_in;
            pend_d       = 1'b1;
         end
      end

      vld_d      = {vld_q[LAT-2:0], sample_en};
      s1_phase_d = p_used[PHASE_W-1 -: SL_W];
      s1_wave_d  = wave_sel;

      // S2: quadrant fold. Odd quadrants read the table backwards from Q.
      s1_addr = s1_phase_q[SL_W-1 -: ADDR_W];
      s1_k    = s1_addr[K_W-1:0];
      s1_idx  = s1_addr[ADDR_W-2] ? (Q_I - {1'b0, s1_k}) : {1'b0, s1_k};
      s2_rom_d     = ROM[int'(s1_idx)*DATA_W +: DATA_W];
      s2_neg_d     = s1_addr[ADDR_W-1];
      s2_is_sine_d = (s1_wave_q == 2'd0);

      s1_u     = s1_phase_q[SL_W-1 -: DATA_W+1];
      s2_alt_d = '0;
      case (s1_wave_q)
         2'd1:    s2_alt_d = s1_u[DATA_W] ? '0 : '1;
         2'd2:    s2_alt_d = s1_u[DATA_W:1];
         2'd3:    s2_alt_d = s1_u[DATA_W] ? ~s1_u[DATA_W-1:0] : s1_u[DATA_W-1:0];
         default: s2_alt_d = '0;
      endcase

      // S3: offset-binary sample
      if (s2_is_sine_q) raw = s2_neg_q ? (M_D - s2_rom_q) : (M_D + s2_rom_q);
      else              raw = s2_alt_q;

`ifdef SINE_NCO_AMP_EN
      s1_amp_d = amp;
      s2_amp_d = s1_amp_q;
      s3_amp_d = s2_amp_q;
      s3_raw_d = raw;
      // Scale the deviation from mid-scale; the result always fits DATA_W.
      amp_dev  = $signed({1'b0, s3_raw_q}) - $signed({1'b0, M_D});
      amp_prod = amp_dev * $signed({1'b0, s3_amp_q});
      amp_sh   = amp_prod >>> 8;
      sine_d   = vld_q[LAT-2] ? (M_D + amp_sh[DATA_W-1:0]) : sine_q;
`else
      sine_d   = vld_q[LAT-2] ? raw : sine_q;
`endif
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         phase_q      <= '0;
         tw_active_q  <= '0;
         tw_pending_q <= '0;
         pend_q       <= 1'b0;
         vld_q        <= '0;
         s1_phase_q   <= '0;
         s1_wave_q    <= '0;
         s2_rom_q     <= '0;
         s2_neg_q     <= 1'b0;
         s2_is_sine_q <= 1'b0;
         s2_alt_q     <= '0;
         sine_q       <= M_D;
`ifdef SINE_NCO_AMP_EN
         s1_amp_q     <= '0;
         s2_amp_q     <= '0;
         s3_amp_q     <= '0;
         s3_raw_q     <= '0;
`endif
      end else begin
         phase_q      <= phase_d;
         tw_active_q  <= tw_active_d;
         tw_pending_q <= tw_pending_d;
         pend_q       <= pend_d;
         vld_q        <= vld_d;
         s1_phase_q   <= s1_phase_d;
         s1_wave_q    <= s1_wave_d;
         s2_rom_q     <= s2_rom_d;
         s2_neg_q     <= s2_neg_d;
         s2_is_sine_q <= s2_is_sine_d;
         s2_alt_q     <= s2_alt_d;
         sine_q       <= sine_d;
`ifdef SINE_NCO_AMP_EN
         s1_amp_q     <= s1_amp_d;
         s2_amp_q     <= s2_amp_d;
         s3_amp_q     <= s3_amp_d;
         s3_raw_q     <= s3_raw_d;
`endif
      end
   end

   assign sine      = sine_q;
   assign out_valid = vld_q[LAT-1];

endmodule
